// File: rtl/repair_mapper_if.sv
// repair_mapper_if: access request and remapped response bundle.
// master drives req_*, slave returns registered rsp_*.
interface repair_mapper_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic             req_valid;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             rsp_valid;
  logic [ROW_W-1:0] rsp_row;
  logic [COL_W-1:0] rsp_col;
  logic [2:0]       rsp_sel;
  logic             rsp_fail;

  modport master (
    output req_valid, req_row, req_col,
    input  rsp_valid, rsp_row, rsp_col,
    input  rsp_sel, rsp_fail
  );

  modport slave (
    input  req_valid, req_row, req_col,
    output rsp_valid, rsp_row, rsp_col,
    output rsp_sel, rsp_fail
  );
endinterface

// File: rtl/repair_mapper.sv
// repair_mapper: holds the BIRA spare map and steers each access
// to main array / spare row0,row1 / spare col0,col1.
// Ports: clk, rst (async low), test/repair/early_term/solution from
// the analyzer, bus (slave req/rsp), armed/failed/spares_used/sol_err.
module repair_mapper #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          test,
  input  logic                          repair,
  input  logic                          early_term,
  input  logic [2*(1+ROW_W)+2*(1+COL_W)-1:0] solution,
  repair_mapper_if.slave                bus,
  output logic                          armed,
  output logic                          failed,
  output logic [2:0]                    spares_used,
  output logic                          sol_err
);

  localparam int SOL_W = 2*(1+ROW_W) + 2*(1+COL_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FAIL  = 2'd2
  } state_t;

  typedef struct packed {
    logic             r0_en;
    logic [ROW_W-1:0] r0;
    logic             r1_en;
    logic [ROW_W-1:0] r1;
    logic             c0_en;
    logic [COL_W-1:0] c0;
    logic             c1_en;
    logic [COL_W-1:0] c1;
  } map_t;

  state_t           state_q;
  map_t             map_q;
  logic [2:0]       spares_q;
  logic             err_q;
  logic             test_q;
  logic             rep_q, rep_qq;
  logic             et_q, et_qq;
  logic [SOL_W-1:0] sol_q;
  logic             rsp_valid_q;
  logic             rsp_fail_q;
  logic [ROW_W-1:0] rsp_row_q;
  logic [COL_W-1:0] rsp_col_q;
  logic [2:0]       rsp_sel_q;

  logic             rep_rise, et_rise;
  map_t             ld;
  logic [2:0]       pop_d;
  logic             dup_d;
  logic [2:0]       sel_d;

  // Inputs are registered once before edge detection, so a
  // decision lands two edges after the input rises.
  always_comb begin
    rep_rise = rep_q & ~rep_qq;
    et_rise  = et_q & ~et_qq;
    ld       = map_t'(sol_q);
    pop_d    = 3'(ld.r0_en) + 3'(ld.r1_en)
             + 3'(ld.c0_en) + 3'(ld.c1_en);
    dup_d    = (ld.r0_en & ld.r1_en & (ld.r0 == ld.r1))
             | (ld.c0_en & ld.c1_en & (ld.c0 == ld.c1));
  end

  // Rows are checked before columns; first hit wins.
  always_comb begin
    sel_d = 3'd0;
    if (state_q == ARMED) begin
      priority case (1'b1)
        map_q.r0_en && (bus.req_row == map_q.r0): sel_d = 3'd1;
        map_q.r1_en && (bus.req_row == map_q.r1): sel_d = 3'd2;
        map_q.c0_en && (bus.req_col == map_q.c0): sel_d = 3'd3;
        map_q.c1_en && (bus.req_col == map_q.c1): sel_d = 3'd4;
        default:                                  sel_d = 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      map_q       <= '0;
      spares_q    <= '0;
      err_q       <= 1'b0;
      test_q      <= 1'b0;
      rep_q       <= 1'b0;
      rep_qq      <= 1'b0;
      et_q        <= 1'b0;
      et_qq       <= 1'b0;
      sol_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fail_q  <= 1'b0;
      rsp_row_q   <= '0;
      rsp_col_q   <= '0;
      rsp_sel_q   <= '0;
    end else begin
      test_q <= test;
      rep_q  <= repair;
      rep_qq <= rep_q;
      et_q   <= early_term;
      et_qq  <= et_q;
      sol_q  <= solution;

      if (test_q) begin
        state_q  <= IDLE;
        map_q    <= '0;
        spares_q <= '0;
        err_q    <= 1'b0;
      end else if (et_rise) begin
        state_q <= FAIL;
        map_q   <= '0;
      end else if (rep_rise) begin
        state_q  <= ARMED;
        map_q    <= ld;
        spares_q <= pop_d;
        err_q    <= dup_d;
      end

      // Request uses the map as it stands this cycle.
      rsp_valid_q <= bus.req_valid;
      rsp_fail_q  <= bus.req_valid & (state_q == FAIL);
      if (bus.req_valid) begin
        rsp_row_q <= bus.req_row;
        rsp_col_q <= bus.req_col;
        rsp_sel_q <= sel_d;
      end
    end
  end

  assign armed         = (state_q == ARMED);
  assign failed        = (state_q == FAIL);
  assign spares_used   = spares_q;
  assign sol_err       = err_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fail  = rsp_fail_q;
  assign bus.rsp_row   = rsp_row_q;
  assign bus.rsp_col   = rsp_col_q;
  assign bus.rsp_sel   = rsp_sel_q;

endmodule
